regfile_decode_p: RTL
=====================

REGFILE_DECODE_P -- requirements
Module: regfile_decode_p

Parameters
REQ-001 SHALL provide DATA_W, default 64: width of every register and data port.
REQ-002 SHALL provide NREG, default 15: number of architectural registers (IDs 0..NREG-1); ID 4'hF = RNONE; legal range 5..15.
REQ-003 SHALL provide SP_RESET, default 32: reset value of register 4 (%rsp).

Interface
REQ-004 SHALL provide clk, input, 1: sole clock; all state updates on rising edge.
REQ-005 SHALL provide rst, input, 1: synchronous, active-high reset.
REQ-006 SHALL provide in_valid, input, 1: icode/rA/rB qualify a decode request this cycle.
REQ-007 SHALL provide stall, input, 1: hold all decode outputs.
REQ-008 SHALL provide icode, input, 4: instruction class.
REQ-009 SHALL provide rA, input, 4 and rB, input, 4: register specifiers.
REQ-010 SHALL provide e_wen, input, 1; dstE, input, 4; valE, input, DATA_W: execute write-back port.
REQ-011 SHALL provide m_wen, input, 1; dstM, input, 4; valM, input, DATA_W: memory write-back port.
REQ-012 SHALL provide out_valid, output, 1: registered decode result valid.
REQ-013 SHALL provide srcA, output, 4 and srcB, output, 4: registered resolved source IDs.
REQ-014 SHALL provide valA, output, DATA_W and valB, output, DATA_W: registered operands.

Function
REQ-015 Source select SHALL be: srcA = rA for icode 2,4,6,10; 4 for icode 9,11; else RNONE.
REQ-016 Source select SHALL be: srcB = rB for icode 4,5,6; 4 for icode 8,9,10,11; else RNONE.
REQ-017 Operand read for a source equal to RNONE or >= NREG SHALL yield 0.
REQ-018 Decode latency SHALL be one cycle: request sampled at edge N appears on outputs after edge N, out_valid = in_valid of that request.
REQ-019 With stall=1, outputs SHALL hold their values; write-back SHALL still occur.
REQ-020 Write-back SHALL update register dstE with valE when e_wen=1, dstE<NREG, and likewise for port M, on the rising edge.
REQ-021 dstE/dstM = RNONE or >= NREG SHALL cause no write.
REQ-022 When dstE = dstM and both enabled, valM SHALL win.
REQ-023 Bypass: when a read samples a register being written the same edge, operand SHALL be the written value (M over E priority), never the stale value.
REQ-024 While stall=1, held outputs SHALL NOT be refreshed by write-backs (no retroactive bypass).
REQ-025 Reads of different sources SHALL be independent; srcA = srcB SHALL return identical values.

Reset
REQ-026 On rst=1 at a rising edge: register i SHALL load i (zero-extended), except register 4 loads SP_RESET.
REQ-027 On reset, out_valid SHALL be 0, srcA/srcB SHALL be RNONE, valA/valB SHALL be 0.
REQ-028 rst SHALL override stall, in_valid and both write ports in the same cycle; no write-back commits.
REQ-029 First request after deassertion SHALL observe reset register values.

Verification
REQ-030 Reset then icode=6, rA=2, rB=3 -> next cycle out_valid=1, srcA=2, srcB=3, valA=2, valB=3.
REQ-031 Reset then icode=11 (popq) -> srcA=srcB=4, valA=valB=32.
REQ-032 Same edge: e_wen=1 dstE=5 valE=0xAA, m_wen=1 dstM=5 valM=0xBB, icode=6 rA=5 rB=5 -> valA=valB=0xBB; later read of r5 = 0xBB.
REQ-033 icode=2 rA=7 -> valA=7, srcB=RNONE, valB=0; write to dstE=4'hF -> no register changes.
REQ-034 Decode latched, then stall=1 for 3 cycles with write to the read register -> outputs unchanged during stall; after release, new request reads updated value.
REQ-035 Write r1=0x55 then assert rst with concurrent write r1=0x77 -> r1 reads 1, out_valid=0 in the reset cycle.

Source files
------------

// File: rtl/regfile_decode_p.sv
// rtl/regfile_decode_p.sv - register file with one-cycle decode/operand read and two write-back ports
module regfile_decode_p #(
  parameter int DATA_W   = 64,
  parameter int NREG     = 15,
  parameter int SP_RESET = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              stall,
  input  logic [3:0]        icode,
  input  logic [3:0]        rA,
  input  logic [3:0]        rB,
  input  logic              e_wen,
  input  logic [3:0]        dstE,
  input  logic [DATA_W-1:0] valE,
  input  logic              m_wen,
  input  logic [3:0]        dstM,
  input  logic [DATA_W-1:0] valM,
  output logic              out_valid,
  output logic [3:0]        srcA,
  output logic [3:0]        srcB,
  output logic [DATA_W-1:0] valA,
  output logic [DATA_W-1:0] valB
);

  localparam logic [3:0] RNONE = 4'hF;

  logic [DATA_W-1:0] r_regs [NREG];
  logic [3:0]        w_src_a;
  logic [3:0]        w_src_b;
  logic [DATA_W-1:0] w_val_a;
  logic [DATA_W-1:0] w_val_b;

  // Same-edge write-backs are forwarded so a read never sees the stale value; M beats E.
  function automatic logic [DATA_W-1:0] read_op(input logic [3:0] src);
    logic [DATA_W-1:0] v;
    v = '0;
    for (int i = 0; i < NREG; i++) begin
      if (src == 4'(i)) v = r_regs[i];
    end
    if (src < 4'(NREG)) begin
      if (e_wen && dstE == src) v = valE;
      if (m_wen && dstM == src) v = valM;
    end
    return v;
  endfunction

  always_comb begin
    w_src_a = RNONE;
    w_src_b = RNONE;
    case (icode)
      4'd2, 4'd4, 4'd6, 4'd10: w_src_a = rA;
      4'd9, 4'd11:             w_src_a = 4'd4;
      default:                 w_src_a = RNONE;
    endcase
    case (icode)
      4'd4, 4'd5, 4'd6:          w_src_b = rB;
      4'd8, 4'd9, 4'd10, 4'd11:  w_src_b = 4'd4;
      default:                   w_src_b = RNONE;
    endcase
    w_val_a = read_op(w_src_a);
    w_val_b = read_op(w_src_b);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        r_regs[i] <= (i == 4) ? DATA_W'(SP_RESET) : DATA_W'(i);
      end
      out_valid <= 1'b0;
      srcA      <= RNONE;
      srcB      <= RNONE;
      valA      <= '0;
      valB      <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (m_wen && dstM == 4'(i))      r_regs[i] <= valM;
        else if (e_wen && dstE == 4'(i)) r_regs[i] <= valE;
      end
      if (!stall) begin
        out_valid <= in_valid;
        srcA      <= w_src_a;
        srcB      <= w_src_b;
        valA      <= w_val_a;
        valB      <= w_val_b;
      end
    end
  end

endmodule
